int_to_fp_pipe: RTL and testbench
=================================

# int_to_fp_pipe

Pipelined, parametrised integer-to-floating-point converter, the successor of the single-stage converter in the FPU's conversion path. It accepts a signed or unsigned integer of any width and produces a correctly rounded IEEE-754-style result. It supports four rounding modes, raises inexact/overflow flags and uses valid/ready handshaking on both sides. It sits between the integer register-file read port and the FP result writeback.

## Interface
- `INT_SIZE`, 32, integer operand width (≥ 2)
- `EXPONENT_SIZE`, 8, exponent field width
- `MANTISSA_SIZE`, 23, stored fraction width
- `PRECISION`, 1 + `EXPONENT_SIZE` + `MANTISSA_SIZE`, output width
- `clk`  in  1  clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `in_valid`  in  1  operand present
- `in_ready`  out  1  converter accepts operand this cycle
- `int`  in  `INT_SIZE`  integer operand
- `is_signed`  in  1  1 = two's complement, 0 = unsigned
- `rnd_mode`  in  2  00 RNE, 01 RTZ, 10 RDN (toward −inf), 11 RUP (toward +inf)
- `out_valid`  out  1  result present
- `out_ready`  in  1  consumer accepts result
- `fp`  out  `PRECISION`  {sign, exponent, fraction}
- `inexact`  out  1  result ≠ exact operand value
- `overflow`  out  1  magnitude exceeded largest finite value

## Operation
- Bias = 2^(`EXPONENT_SIZE`−1) − 1.
- **S1 (sign/abs):**
  - sign = `is_signed` & `int`[MSB].
  - mag = sign ? −`int` : `int`, computed as an `INT_SIZE`-bit unsigned value. The most negative signed value gives mag = 2^(`INT_SIZE`−1) with no special case.
  - Latch `rnd_mode`.
- **S2 (normalise):**
  - p = index of the leading one of mag.
  - Left-shift mag so the bit at p lands in the hidden position.
  - Fraction = next `MANTISSA_SIZE` bits; guard = following bit; sticky = OR of all remaining bits.
  - When p ≤ `MANTISSA_SIZE`, guard = sticky = 0 (exact).
  - Unbiased exponent = p.
- **S3 (round/pack):**
  - Increment decision:
    - RNE: guard & (sticky | frac LSB).
    - RTZ: never.
    - RDN: sign & (guard | sticky).
    - RUP: !sign & (guard | sticky).
  - Rounding carry out of the fraction sets fraction = 0 and exponent + 1.
  - Biased exponent = bias + p (+ carry), computed wide enough to never wrap.
  - `inexact` = guard | sticky.
- **Overflow:** biased exponent ≥ all-ones sets `overflow` = 1 and `inexact` = 1. The result then depends on the mode:
  - RNE: ±inf.
  - RTZ: ±max-finite.
  - RDN: +max-finite / −inf.
  - RUP: +inf / −max-finite.
- **Zero operand:** `fp` = +0 (all zero); flags 0; all modes.
- Output fraction is never denormal; the exponent field is never 0 for nonzero input.

## Timing
- 3-stage pipeline; latency exactly 3 cycles from an accepted operand to `out_valid` with no backpressure. Throughput 1 per cycle.
- Global stall: advance = !`out_valid` | `out_ready`; `in_ready` = advance (combinational).
- Each stage carries a valid bit. Bubbles propagate but do not collapse while stalled.
- Transfer rules:
  - Input transfers on `in_valid` & `in_ready`.
  - Output transfers on `out_valid` & `out_ready`.
  - While `out_valid` & !`out_ready`: `fp`, `inexact` and `overflow` are held stable and all stages freeze.
- Reset (synchronous, any cycle including mid-stream): all stage valid bits clear, so `out_valid` = 0 on the next edge and in-flight operands are discarded.
  - `fp` = 0, `inexact` = 0, `overflow` = 0 after reset.
  - `in_ready` = 1 in the cycle after reset.
- `in_valid` with `int` = X while `in_ready` = 0 must not corrupt state.

## Test plan
- Defaults, RNE, signed: the following back-to-back inputs give `out_valid` at cycles 3, 4, 5, 6.
  - 1 → 0x3F800000.
  - −1 (0xFFFFFFFF) → 0xBF800000.
  - 0 → 0x00000000.
  - 0x80000000 → 0xCF000000, `inexact` = 0.
- 0x7FFFFFFF signed:
  - RNE → 0x4F000000, `inexact` = 1.
  - RTZ → 0x4EFFFFFF.
- Unsigned 0x80000000 → 0x4F000000.
- Unsigned 0x01000001 (exact tie):
  - RNE → 0x4B800000.
  - RUP → 0x4B800001.
  - RDN → 0x4B800000.
  - `inexact` = 1 in all three.
- `EXPONENT_SIZE` = 5, `MANTISSA_SIZE` = 10, unsigned:
  - 65504 → 0x7BFF, exact.
  - 65520 RNE → 0x7C00, `overflow` = 1.
  - 65520 RTZ → 0x7BFF, `overflow` = 1.
- Backpressure: stream 8 operands while `out_ready` toggles randomly → all 8 results in order, none duplicated or lost. Outputs hold while stalled; `in_ready` mirrors advance.
- Assert `reset` for 1 cycle with 3 operands in flight:
  - `out_valid` = 0 next cycle.
  - No stale result appears.
  - A new operand then emerges after exactly 3 cycles.

Source files
------------

// File: rtl/int_to_fp_pipe.sv
// Pipelined integer to IEEE-754-style float converter with four rounding modes and inexact/overflow flags.
// Latency: 3 cycles from an accepted operand to o_out_valid; one result per cycle when not stalled.
// Backpressure: one global stall; all stages freeze while o_out_valid & !i_out_ready, and o_in_ready drops with it.
module int_to_fp_pipe #(
    parameter int INT_SIZE      = 32,
    parameter int EXPONENT_SIZE = 8,
    parameter int MANTISSA_SIZE = 23,
    parameter int PRECISION     = 1 + EXPONENT_SIZE + MANTISSA_SIZE
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [INT_SIZE-1:0]  i_int,
    input  logic                 i_is_signed,
    input  logic [1:0]           i_rnd_mode,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [PRECISION-1:0] o_fp,
    output logic                 o_inexact,
    output logic                 o_overflow
);

    // Width of the leading-one index (0 .. INT_SIZE-1).
    localparam int PW = (INT_SIZE > 1) ? $clog2(INT_SIZE) : 1;
    // Normaliser working width: operand plus room for fraction, guard and one spare bit.
    localparam int NW = INT_SIZE + MANTISSA_SIZE + 2;
    // Shift amount width; the largest shift is INT_SIZE-1.
    localparam int SW = $clog2(NW + 1);
    // Exponent arithmetic width; two spare bits so bias + p + carry can never wrap.
    localparam int EW = ((EXPONENT_SIZE > PW) ? EXPONENT_SIZE : PW) + 2;

    localparam logic [EW-1:0] BIAS    = EW'((1 << (EXPONENT_SIZE - 1)) - 1);
    localparam logic [EW-1:0] EXP_MAX = EW'((1 << EXPONENT_SIZE) - 1);

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RTZ = 2'b01,
        RM_RDN = 2'b10,
        RM_RUP = 2'b11
    } rnd_t;

    // ------------------------------------------------------------------
    // Pipeline control
    // ------------------------------------------------------------------
    logic w_advance;

    logic                     r1_vld;
    logic                     r1_sign;
    logic [INT_SIZE-1:0]      r1_mag;
    rnd_t                     r1_rnd;

    logic                     r2_vld;
    logic                     r2_sign;
    logic                     r2_zero;
    logic [PW-1:0]            r2_p;
    logic [MANTISSA_SIZE-1:0] r2_frac;
    logic                     r2_guard;
    logic                     r2_sticky;
    rnd_t                     r2_rnd;

    logic                     r3_vld;
    logic [PRECISION-1:0]     r_fp;
    logic                     r_inexact;
    logic                     r_overflow;

    // The whole pipe moves together unless a finished result is waiting on the consumer.
    assign w_advance   = !r3_vld || i_out_ready;
    assign o_in_ready  = w_advance;
    assign o_out_valid = r3_vld;
    assign o_fp        = r_fp;
    assign o_inexact   = r_inexact;
    assign o_overflow  = r_overflow;

    // ------------------------------------------------------------------
    // Stage 1: sign and magnitude
    // ------------------------------------------------------------------
    logic                w_sign;
    logic [INT_SIZE-1:0] w_mag;

    // Two's-complement negate wraps the most negative value onto 2^(INT_SIZE-1), which is its true magnitude.
    assign w_sign = i_is_signed & i_int[INT_SIZE-1];
    assign w_mag  = w_sign ? ((~i_int) + INT_SIZE'(1)) : i_int;

    // Stage 1 register; data only loads with a real operand so held bubbles keep old contents.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r1_vld  <= 1'b0;
            r1_sign <= 1'b0;
            r1_mag  <= '0;
            r1_rnd  <= RM_RNE;
        end else if (w_advance) begin
            r1_vld <= i_in_valid;
            if (i_in_valid) begin
                r1_sign <= w_sign;
                r1_mag  <= w_mag;
                r1_rnd  <= rnd_t'(i_rnd_mode);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: leading-one detect and normalise
    // ------------------------------------------------------------------
    logic [PW-1:0]            w_lead;
    logic                     w_zero;
    logic [SW-1:0]            w_shamt;
    logic [NW-1:0]            w_ext;
    logic [NW-2:0]            w_norm;
    logic [MANTISSA_SIZE-1:0] w_frac;
    logic                     w_guard;
    logic                     w_sticky;

    // Priority scan from LSB upward so the highest set bit wins.
    always_comb begin
        w_lead = '0;
        for (int i = 0; i < INT_SIZE; i++) begin
            if (r1_mag[i]) begin
                w_lead = PW'(i);
            end
        end
    end

    assign w_zero  = ~|r1_mag;
    assign w_shamt = SW'(INT_SIZE - 1) - SW'(w_lead);
    assign w_ext   = {r1_mag, {(MANTISSA_SIZE + 2){1'b0}}};
    // After the shift the leading one sits in the top bit (the hidden bit), which is dropped here.
    assign w_norm  = (NW - 1)'(w_ext << w_shamt);

    // Zero padding below the operand makes guard/sticky naturally 0 when p <= MANTISSA_SIZE.
    assign w_frac   = w_norm[NW-2 -: MANTISSA_SIZE];
    assign w_guard  = w_norm[NW-2-MANTISSA_SIZE];
    assign w_sticky = |w_norm[NW-3-MANTISSA_SIZE:0];

    // Stage 2 register holding the normalised fields ready for rounding.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r2_vld    <= 1'b0;
            r2_sign   <= 1'b0;
            r2_zero   <= 1'b0;
            r2_p      <= '0;
            r2_frac   <= '0;
            r2_guard  <= 1'b0;
            r2_sticky <= 1'b0;
            r2_rnd    <= RM_RNE;
        end else if (w_advance) begin
            r2_vld <= r1_vld;
            if (r1_vld) begin
                r2_sign   <= r1_sign;
                r2_zero   <= w_zero;
                r2_p      <= w_lead;
                r2_frac   <= w_frac;
                r2_guard  <= w_guard;
                r2_sticky <= w_sticky;
                r2_rnd    <= r1_rnd;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: round, range check, pack
    // ------------------------------------------------------------------
    logic                     w_inc;
    logic                     w_inc_rne;
    logic                     w_carry;
    logic                     w_carry_rne;
    logic [MANTISSA_SIZE-1:0] w_frac_rnd;
    logic [EW-1:0]            w_exp_base;
    logic [EW-1:0]            w_exp;
    logic [EW-1:0]            w_exp_rne;
    logic                     w_ovf;
    logic                     w_sat;
    logic [PRECISION-1:0]     w_fp;
    logic                     w_inexact;
    logic                     w_overflow;

    // Round-up decision for the selected mode.
    always_comb begin
        w_inc = 1'b0;
        case (r2_rnd)
            RM_RNE:  w_inc = r2_guard & (r2_sticky | r2_frac[0]);
            RM_RTZ:  w_inc = 1'b0;
            RM_RDN:  w_inc = r2_sign & (r2_guard | r2_sticky);
            RM_RUP:  w_inc = !r2_sign & (r2_guard | r2_sticky);
            default: w_inc = 1'b0;
        endcase
    end

    assign w_inc_rne   = r2_guard & (r2_sticky | r2_frac[0]);
    // A carry out of the fraction only happens from an all-ones fraction; the sum then wraps to zero.
    assign w_carry     = w_inc & (&r2_frac);
    assign w_carry_rne = w_inc_rne & (&r2_frac);
    assign w_frac_rnd  = r2_frac + MANTISSA_SIZE'(w_inc);

    assign w_exp_base = BIAS + EW'(r2_p);
    assign w_exp      = w_exp_base + EW'(w_carry);
    assign w_exp_rne  = w_exp_base + EW'(w_carry_rne);

    // Out of range if the mode's own rounding lands on the reserved exponent, or if the value is
    // already past the round-to-nearest threshold; truncating modes then saturate but still flag it.
    assign w_ovf = (w_exp >= EXP_MAX) || (w_exp_rne >= EXP_MAX);

    // Overflowing modes that round toward zero for this sign saturate to max-finite instead of inf.
    always_comb begin
        w_sat = 1'b0;
        case (r2_rnd)
            RM_RNE:  w_sat = 1'b0;
            RM_RTZ:  w_sat = 1'b1;
            RM_RDN:  w_sat = !r2_sign;
            RM_RUP:  w_sat = r2_sign;
            default: w_sat = 1'b0;
        endcase
    end

    // Final result selection: zero, overflow (inf or max-finite), or the normally rounded value.
    always_comb begin
        w_fp       = {r2_sign, w_exp[EXPONENT_SIZE-1:0], w_frac_rnd};
        w_inexact  = r2_guard | r2_sticky;
        w_overflow = 1'b0;
        if (r2_zero) begin
            w_fp      = '0;
            w_inexact = 1'b0;
        end else if (w_ovf) begin
            w_overflow = 1'b1;
            w_inexact  = 1'b1;
            if (w_sat) begin
                w_fp = {r2_sign, {(EXPONENT_SIZE - 1){1'b1}}, 1'b0, {MANTISSA_SIZE{1'b1}}};
            end else begin
                w_fp = {r2_sign, {EXPONENT_SIZE{1'b1}}, {MANTISSA_SIZE{1'b0}}};
            end
        end
    end

    // Output register; holds its value whenever the pipe is stalled or a bubble passes.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r3_vld     <= 1'b0;
            r_fp       <= '0;
            r_inexact  <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_advance) begin
            r3_vld <= r2_vld;
            if (r2_vld) begin
                r_fp       <= w_fp;
                r_inexact  <= w_inexact;
                r_overflow <= w_overflow;
            end
        end
    end

endmodule

// File: tb/tb_int_to_fp_pipe.sv
// Directed bench for int_to_fp_pipe: single precision and half precision instances share one stimulus stream.
// Checks reset state, rounding modes, overflow saturation, latency, backpressure ordering and mid-stream reset.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_int_to_fp_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] op_int;
    logic        is_signed;
    logic [1:0]  rnd_mode;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [31:0] fp;
    logic        inexact;
    logic        overflow;

    logic        h_in_ready;
    logic        h_out_valid;
    logic [15:0] h_fp;
    logic        h_inexact;
    logic        h_overflow;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    int_to_fp_pipe #(.INT_SIZE(32), .EXPONENT_SIZE(8), .MANTISSA_SIZE(23)) dut (
        .i_clk(clk), .i_reset(reset), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_int(op_int), .i_is_signed(is_signed), .i_rnd_mode(rnd_mode),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_fp(fp),
        .o_inexact(inexact), .o_overflow(overflow)
    );

    int_to_fp_pipe #(.INT_SIZE(32), .EXPONENT_SIZE(5), .MANTISSA_SIZE(10)) dut_h (
        .i_clk(clk), .i_reset(reset), .i_in_valid(in_valid), .o_in_ready(h_in_ready),
        .i_int(op_int), .i_is_signed(is_signed), .i_rnd_mode(rnd_mode),
        .o_out_valid(h_out_valid), .i_out_ready(out_ready), .o_fp(h_fp),
        .o_inexact(h_inexact), .o_overflow(h_overflow)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] v;
        logic        sg;
        logic [1:0]  rm;
        logic [31:0] f32;
        logic        x32;
        logic        c16;
        logic [15:0] f16;
        logic        x16;
        logic        o16;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [31:0] v, input logic sg, input logic [1:0] rm,
                       input logic [31:0] f32, input logic x32,
                       input logic c16, input logic [15:0] f16, input logic x16, input logic o16);
        vec_t e;
        e = '{v, sg, rm, f32, x32, c16, f16, x16, o16};
        vq.push_back(e);
    endtask

    // One operand through an otherwise empty pipe; result captured when out_valid rises.
    task automatic convert(input logic [31:0] v, input logic sg, input logic [1:0] rm,
                           output logic [31:0] f, output logic x, output logic o,
                           output logic [15:0] hf, output logic hx, output logic ho);
        int k;
        @(negedge clk);
        op_int = v; is_signed = sg; rnd_mode = rm; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("conv_timeout", {63'd0, out_valid}, 64'd1);
        f = fp; x = inexact; o = overflow;
        hf = h_fp; hx = h_inexact; ho = h_overflow;
    endtask

    logic [31:0] b_in  [4] = '{32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    logic [31:0] b_f32 [4] = '{32'h3F800000, 32'hBF800000, 32'h00000000, 32'hCF000000};
    logic [15:0] b_f16 [4] = '{16'h3C00, 16'hBC00, 16'h0000, 16'hFC00};
    logic        b_x16 [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] bp_exp[8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                               32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] f;
        logic        x, o, hx, ho;
        logic [15:0] hf;
        int          tx, rx;
        logic        in_fire, out_fire, prev_stall;
        logic [31:0] prev_fp;

        reset = 1'b1; in_valid = 1'b0; op_int = '0; is_signed = 1'b1;
        rnd_mode = 2'd0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_fp", {32'd0, fp}, 64'd0);
        check("rst_inexact", {63'd0, inexact}, 64'd0);
        check("rst_overflow", {63'd0, overflow}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Back-to-back: first result after exactly three edges, then one per cycle.
        for (int c = 0; c < 8; c++) begin
            if (c < 3) begin
                check("b2b_latency", {63'd0, out_valid}, 64'd0);
            end else if (c < 7) begin
                check("b2b_valid", {63'd0, out_valid}, 64'd1);
                check("b2b_fp", {32'd0, fp}, {32'd0, b_f32[c-3]});
                check("b2b_inexact", {63'd0, inexact}, 64'd0);
                check("b2b_h_fp", {48'd0, h_fp}, {48'd0, b_f16[c-3]});
                check("b2b_h_ovf", {63'd0, h_overflow}, {63'd0, b_x16[c-3]});
            end else begin
                check("b2b_tail", {63'd0, out_valid}, 64'd0);
            end
            if (c < 4) begin
                op_int = b_in[c]; is_signed = 1'b1; rnd_mode = 2'd0; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end

        // Directed rounding / overflow vectors (modes: 0 RNE, 1 RTZ, 2 RDN, 3 RUP).
        add(32'h7FFFFFFF, 1, 0, 32'h4F000000, 1, 0, 16'h0000, 0, 0);
        add(32'h7FFFFFFF, 1, 1, 32'h4EFFFFFF, 1, 0, 16'h0000, 0, 0);
        add(32'h80000000, 0, 0, 32'h4F000000, 0, 0, 16'h0000, 0, 0);
        add(32'h01000001, 0, 0, 32'h4B800000, 1, 0, 16'h0000, 0, 0);
        add(32'h01000001, 0, 3, 32'h4B800001, 1, 0, 16'h0000, 0, 0);
        add(32'h01000001, 0, 2, 32'h4B800000, 1, 0, 16'h0000, 0, 0);
        add(32'h01000003, 0, 0, 32'h4B800002, 1, 0, 16'h0000, 0, 0);
        add(32'hFEFFFFFF, 1, 1, 32'hCB800000, 1, 0, 16'h0000, 0, 0);
        add(32'hFEFFFFFF, 1, 2, 32'hCB800001, 1, 0, 16'h0000, 0, 0);
        add(32'd65504,    0, 0, 32'h477FE000, 0, 1, 16'h7BFF, 0, 0);
        add(32'd65520,    0, 0, 32'h477FF000, 0, 1, 16'h7C00, 1, 1);
        add(32'd65520,    0, 1, 32'h477FF000, 0, 1, 16'h7BFF, 1, 1);
        add(32'd65520,    0, 2, 32'h477FF000, 0, 1, 16'h7BFF, 1, 1);
        add(32'd65520,    0, 3, 32'h477FF000, 0, 1, 16'h7C00, 1, 1);
        add(32'hFFFF0010, 1, 2, 32'hC77FF000, 0, 1, 16'hFC00, 1, 1);
        add(32'hFFFF0010, 1, 3, 32'hC77FF000, 0, 1, 16'hFBFF, 1, 1);
        add(32'h00000000, 1, 3, 32'h00000000, 0, 1, 16'h0000, 0, 0);

        foreach (vq[i]) begin
            convert(vq[i].v, vq[i].sg, vq[i].rm, f, x, o, hf, hx, ho);
            check($sformatf("vec%0d_fp", i), {32'd0, f}, {32'd0, vq[i].f32});
            check($sformatf("vec%0d_inexact", i), {63'd0, x}, {63'd0, vq[i].x32});
            check($sformatf("vec%0d_overflow", i), {63'd0, o}, 64'd0);
            if (vq[i].c16) begin
                check($sformatf("vec%0d_h_fp", i), {48'd0, hf}, {48'd0, vq[i].f16});
                check($sformatf("vec%0d_h_inexact", i), {63'd0, hx}, {63'd0, vq[i].x16});
                check($sformatf("vec%0d_h_overflow", i), {63'd0, ho}, {63'd0, vq[i].o16});
            end
        end

        // Backpressure: 8 operands, random out_ready, results in order and held while stalled.
        @(negedge clk);
        tx = 0; rx = 0; in_fire = 1'b0; out_fire = 1'b0; prev_stall = 1'b0; prev_fp = '0;
        is_signed = 1'b1; rnd_mode = 2'd0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (in_fire) tx++;
            if (out_fire) rx++;
            in_fire = 1'b0; out_fire = 1'b0;
            if (rx >= 8) break;
            if (prev_stall) begin
                check("bp_hold_valid", {63'd0, out_valid}, 64'd1);
                check("bp_hold_fp", {32'd0, fp}, {32'd0, prev_fp});
            end
            in_valid  = (tx < 8);
            op_int    = 32'(tx + 1);
            out_ready = 1'($urandom_range(0, 1));
            #1;
            check("bp_in_ready", {63'd0, in_ready}, {63'd0, (!out_valid || out_ready)});
            in_fire  = in_valid && in_ready;
            out_fire = out_valid && out_ready;
            if (out_fire) begin
                check($sformatf("bp_res%0d", rx), {32'd0, fp}, {32'd0, bp_exp[rx]});
            end
            prev_stall = out_valid && !out_ready;
            prev_fp    = fp;
            @(negedge clk);
        end
        check("bp_count", 64'(rx), 64'd8);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("bp_no_extra", {63'd0, out_valid}, 64'd0);

        // Reset with three operands in flight.
        is_signed = 1'b1; rnd_mode = 2'd0; in_valid = 1'b1;
        op_int = 32'd3; @(negedge clk);
        op_int = 32'd4; @(negedge clk);
        op_int = 32'd5; @(negedge clk);
        check("rst2_pre_valid", {63'd0, out_valid}, 64'd1);
        reset = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        check("rst2_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst2_fp", {32'd0, fp}, 64'd0);
        check("rst2_flags", {62'd0, inexact, overflow}, 64'd0);
        check("rst2_in_ready", {63'd0, in_ready}, 64'd1);
        reset = 1'b0; op_int = 32'd2; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("rst2_stale1", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        check("rst2_stale2", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        check("rst2_new_valid", {63'd0, out_valid}, 64'd1);
        check("rst2_new_fp", {32'd0, fp}, 64'h40000000);
        @(negedge clk);
        check("rst2_after", {63'd0, out_valid}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
